// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ valid/ready producers.
// Handshake: a word moves from requester i when req_valid[i] and req_ready[i] are both high in a cycle.
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                      clock_1,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      buffer_full,
    output logic [DATA_W-1:0]         data_1,
    output logic                      data_1_en,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic [15:0]               stall_count
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] burst_cnt;

    logic          owner_valid;
    logic          xfer;
    logic          last_word;
    logic          grant_exit;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] arb_ptr;
    logic [IW-1:0] arb_idx;
    logic          arb_found;
    logic [IW-1:0] cand_idx;
    int            cand;

    assign owner_valid = req_valid[owner];
    assign xfer        = (state == GRANT) && owner_valid && !buffer_full;
    assign last_word   = (burst_cnt == BW'(MAX_BURST - 1));
    assign grant_exit  = (state == GRANT) && ((xfer && last_word) || !owner_valid);
    assign next_ptr    = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // In GRANT the search already uses the rotated pointer, so an exit re-arbitrates in the same cycle.
    assign arb_ptr = (state == GRANT) ? next_ptr : rr_ptr;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        // Descending scan: the nearest requester to arb_ptr is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(arb_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IW'(cand);
            if (req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        data_1    = '0;
        data_1_en = xfer;
        if (xfer) begin
            req_ready[owner] = 1'b1;
            data_1           = req_data[int'(owner)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock_1) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            stall_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        owner     <= arb_idx;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        rr_ptr <= next_ptr;
                        if (arb_found) begin
                            owner     <= arb_idx;
                            burst_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if ((state == GRANT) && owner_valid && buffer_full && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign grant_id = owner;
    assign busy     = (state == GRANT);

endmodule
